// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered onto the ALU bus and the result is returned over a valid/ready response.
module alu_arbiter #(
    parameter int WIDTH     = 32,
    parameter int SEL_W     = 4,
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp0_carry,
    output logic             rsp0_ovf,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic             rsp1_carry,
    output logic             rsp1_ovf,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_ovf
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic             prio;
    logic             owner;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             carry_q;
    logic             ovf_q;
    logic             gnt0;
    logic             gnt1;
    logic             rsp_done;

    // prio names the requester that wins when both are valid
    always_comb begin
        gnt0       = req0_valid & (~req1_valid | ~prio);
        gnt1       = req1_valid & (~req0_valid | prio);
        req0_ready = (state == IDLE) & ~rst & gnt0;
        req1_ready = (state == IDLE) & ~rst & gnt1;
        rsp_done   = owner ? rsp1_ready : rsp0_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prio       <= PRIO_INIT;
            owner      <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_valid && req0_ready) begin
                        alu_a   <= req0_a;
                        alu_b   <= req0_b;
                        alu_sel <= req0_sel;
                        owner   <= 1'b0;
                        state   <= EXEC;
                    end else if (req1_valid && req1_ready) begin
                        alu_a   <= req1_a;
                        alu_b   <= req1_b;
                        alu_sel <= req1_sel;
                        owner   <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    result_q   <= alu_out;
                    zero_q     <= alu_zero;
                    carry_q    <= alu_carry;
                    ovf_q      <= alu_ovf;
                    rsp0_valid <= ~owner;
                    rsp1_valid <= owner;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        prio       <= ~owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // both response ports show the shared capture registers; valid qualifies them
    always_comb begin
        rsp0_result = result_q;
        rsp0_zero   = zero_q;
        rsp0_carry  = carry_q;
        rsp0_ovf    = ovf_q;
        rsp1_result = result_q;
        rsp1_zero   = zero_q;
        rsp1_carry  = carry_q;
        rsp1_ovf    = ovf_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, multi-cycle corner sequences
// and a randomized phase checked against a transaction-level reference model.
module tb_alu_arbiter;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        c;
        logic        o;
    } alu_res_t;

    typedef struct packed {
        logic        who;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_sel, req1_sel;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_zero, rsp0_carry, rsp0_ovf, rsp1_zero, rsp1_carry, rsp1_ovf;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_sel;
    logic        alu_zero, alu_carry, alu_ovf;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .SEL_W(4), .PRIO_INIT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_zero(rsp0_zero), .rsp0_carry(rsp0_carry), .rsp0_ovf(rsp0_ovf),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_zero(rsp1_zero), .rsp1_carry(rsp1_carry), .rsp1_ovf(rsp1_ovf),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_ovf(alu_ovf)
    );

    // ALU behaviour: unlisted opcodes fall back to add; carry on SUB is the borrow
    function automatic alu_res_t alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        alu_res_t   x;
        logic [32:0] w;
        x = '0;
        case (s)
            4'b0000: x.r = a & b;
            4'b0001: x.r = a | b;
            4'b0110: begin
                w   = {1'b0, a} - {1'b0, b};
                x.r = w[31:0];
                x.c = w[32];
                x.o = (a[31] != b[31]) && (x.r[31] != a[31]);
            end
            4'b0111: x.r = {31'b0, $signed(a) < $signed(b)};
            4'b1100: x.r = ~(a | b);
            4'b1111: x.r = {31'b0, a == b};
            default: begin
                w   = {1'b0, a} + {1'b0, b};
                x.r = w[31:0];
                x.c = w[32];
                x.o = (a[31] == b[31]) && (x.r[31] != a[31]);
            end
        endcase
        x.z = (x.r == 32'h0);
        return x;
    endfunction

    always_comb {alu_out, alu_zero, alu_carry, alu_ovf} = alu_f(alu_a, alu_b, alu_sel);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_sel = '0;
        req1_a = '0; req1_b = '0; req1_sel = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    endtask

    task automatic apply_reset(input bit check_state);
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        if (check_state) begin
            chk("rst_req_ready", 64'({req1_ready, req0_ready}), 64'd0);
            chk("rst_rsp_valid", 64'({rsp1_valid, rsp0_valid}), 64'd0);
            chk("rst_alu_bus", 64'({alu_a, alu_b, alu_sel} != '0), 64'd0);
            chk("rst_result", 64'({rsp0_result, rsp0_zero, rsp0_carry, rsp0_ovf}), 64'd0);
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic do_op(input vec_t v);
        @(negedge clk);
        if (v.who) begin
            req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_sel = v.sel;
        end else begin
            req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_sel = v.sel;
        end
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        chk("op_req_ready", 64'({req1_ready, req0_ready}), v.who ? 64'd2 : 64'd1);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("op_alu_bus", 64'({alu_a, alu_b[31:0]}), {v.a, v.b});
        chk("op_alu_sel", 64'(alu_sel), 64'(v.sel));
        chk("op_exec_no_rsp", 64'({rsp1_valid, rsp0_valid}), 64'd0);
        @(negedge clk);
        #1;
        chk("op_rsp_valid", 64'({rsp1_valid, rsp0_valid}), v.who ? 64'd2 : 64'd1);
        if (v.who) chk("op_rsp1_data", 64'({rsp1_result, rsp1_zero, rsp1_carry, rsp1_ovf}), 64'({v.res, v.z, v.c, v.o}));
        else       chk("op_rsp0_data", 64'({rsp0_result, rsp0_zero, rsp0_carry, rsp0_ovf}), 64'({v.res, v.z, v.c, v.o}));
        @(negedge clk);
        #1;
        chk("op_rsp_done", 64'({rsp1_valid, rsp0_valid}), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    vec_t vecs [10];
    logic [3:0] ops [8];

    // reference model state (transaction level)
    bit          m_busy, m_owner, m_prio;
    int          m_age;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_sel;

    initial begin
        vecs[0] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0010, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0111, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_1234, 32'h0000_1234, 4'b1111, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_0005, 32'h0000_0005, 4'b0110, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_00F0, 32'h0000_000F, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'h0000_0002, 32'h0000_0003, 4'b0011, 32'h0000_0005, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 32'h0000_00F0, 32'h0000_000F, 4'b0001, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 4'b1100, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 32'h0000_0000, 32'h0000_0001, 4'b0110, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111, 4'b0011};

        idle_inputs();
        rst = 1'b1;
        apply_reset(1'b1);

        for (int i = 0; i < 10; i++) do_op(vecs[i]);

        // backpressure on requester 1 while requester 0 waits
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 32'h1234; req1_b = 32'h1234; req1_sel = 4'b1111;
        rsp1_ready = 1'b0;
        #1;
        chk("bp_req1_ready", 64'(req1_ready), 64'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_sel = 4'b0010;
        #1;
        chk("bp_exec_req0_ready", 64'(req0_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("bp_hold_valid", 64'({rsp1_valid, rsp0_valid}), 64'd2);
            chk("bp_hold_result", 64'(rsp1_result), 64'd1);
            chk("bp_hold_req0_ready", 64'(req0_ready), 64'd0);
        end
        @(negedge clk);
        rsp1_ready = 1'b1;
        #1;
        chk("bp_release_req0_ready", 64'(req0_ready), 64'd0);
        @(negedge clk);
        #1;
        chk("bp_after_rsp1_valid", 64'(rsp1_valid), 64'd0);
        chk("bp_after_req0_ready", 64'(req0_ready), 64'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("bp_req0_result", 64'({rsp0_valid, rsp0_result}), {32'd1, 32'd7});
        @(negedge clk);

        // contention from reset: grants must alternate starting with requester 0
        apply_reset(1'b0);
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd5; req0_sel = 4'b0110;
        req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h0F; req1_sel = 4'b0000;
        for (int g = 0; g < 4; g++) begin
            int n = 0;
            #1;
            while (!req0_ready && !req1_ready && n < 10) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("contention_grant", 64'({req1_ready, req0_ready}), (g % 2 == 1) ? 64'd2 : 64'd1);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) @(negedge clk);

        // reset in EXEC discards the operation and restores priority
        do_op('{1'b0, 32'd1, 32'd1, 4'b0010, 32'd2, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_sel = 4'b0010;
        #1;
        chk("rm_accept", 64'(req0_ready), 64'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rm_alu_bus", 64'({alu_a, alu_b}), 64'd0);
        chk("rm_alu_sel", 64'(alu_sel), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rm_no_rsp", 64'({rsp1_valid, rsp0_valid}), 64'd0);
        end
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3; req0_sel = 4'b0010;
        req1_valid = 1'b1;
        #1;
        chk("rm_prio_reset", 64'({req1_ready, req0_ready}), 64'd1);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rm_next_op", 64'({rsp0_valid, rsp0_result}), {32'd1, 32'd5});
        @(negedge clk);

        // randomized phase against the reference model
        apply_reset(1'b0);
        m_busy = 1'b0; m_owner = 1'b0; m_prio = 1'b0; m_age = 0;
        m_a = '0; m_b = '0; m_sel = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit e_r0, e_r1, e_rv;
            alu_res_t e;
            @(negedge clk);
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_a = pick(); req0_b = pick(); req0_sel = ops[$urandom_range(0, 7)];
            req1_a = pick(); req1_b = pick(); req1_sel = ops[$urandom_range(0, 7)];
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            #1;
            e_r0 = !m_busy && req0_valid && (!req1_valid || !m_prio);
            e_r1 = !m_busy && req1_valid && (!req0_valid || m_prio);
            e_rv = m_busy && (m_age >= 1);
            e    = alu_f(m_a, m_b, m_sel);
            chk("rnd_req_ready", 64'({req1_ready, req0_ready}), 64'({e_r1, e_r0}));
            chk("rnd_rsp_valid", 64'({rsp1_valid, rsp0_valid}), 64'({e_rv && m_owner, e_rv && !m_owner}));
            chk("rnd_alu_bus", 64'({alu_a, alu_b}), {m_a, m_b});
            chk("rnd_alu_sel", 64'(alu_sel), 64'(m_sel));
            if (e_rv && m_owner)  chk("rnd_rsp1_data", 64'({rsp1_result, rsp1_zero, rsp1_carry, rsp1_ovf}), 64'(e));
            if (e_rv && !m_owner) chk("rnd_rsp0_data", 64'({rsp0_result, rsp0_zero, rsp0_carry, rsp0_ovf}), 64'(e));
            if (e_r0) begin
                m_busy = 1'b1; m_age = 0; m_owner = 1'b0;
                m_a = req0_a; m_b = req0_b; m_sel = req0_sel;
            end else if (e_r1) begin
                m_busy = 1'b1; m_age = 0; m_owner = 1'b1;
                m_a = req1_a; m_b = req1_b; m_sel = req1_sel;
            end else if (m_busy) begin
                if (e_rv && (m_owner ? rsp1_ready : rsp0_ready)) begin
                    m_busy = 1'b0;
                    m_prio = !m_owner;
                end else begin
                    m_age++;
                end
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters, for example the integer pipeline (req0) and a multi-cycle helper unit (req1).
- Arbitrates round-robin and registers the winner's operands and opcode onto the ALU input bus.
- Captures the result and flags one cycle later, then returns them to the winning requester over a valid/ready response channel.
- Sits between the requesters and the ALU instance; the ALU itself is unchanged.

Parameters:
- WIDTH, 32, operand/result width.
- SEL_W, 4, ALU opcode width.
- PRIO_INIT, 0, requester holding priority after reset (0 or 1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_sel  in  SEL_W  requester 0 ALU opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel: same as req0_*, for requester 1.
- rsp0_valid  out  1  result available for requester 0.
- rsp0_ready  in  1  requester 0 takes the result.
- rsp0_result  out  WIDTH  captured ALU result.
- rsp0_zero, rsp0_carry, rsp0_ovf  out  1 each  captured ALU flags.
- rsp1_*: same as rsp0_*, for requester 1.
- alu_a, alu_b  out  WIDTH  registered ALU operands.
- alu_sel  out  SEL_W  registered ALU opcode.
- alu_out  in  WIDTH  ALU result.
- alu_zero, alu_carry, alu_ovf  in  1 each  ALU flags.

Behaviour:
- State machine, three states:
  - IDLE -> EXEC on an accepted request.
  - EXEC -> RESP unconditionally.
  - RESP -> IDLE when rsp<owner>_ready=1 while rsp<owner>_valid=1.
- Grant, IDLE only: if exactly one reqN_valid is set, grant N. If both are set, grant the requester holding priority (prio).
- reqN_ready is combinational: (state==IDLE) & granted N. It is 0 in EXEC and RESP. At most one ready is high per cycle.
- On handshake (valid & ready):
  - alu_a/alu_b/alu_sel <= reqN_a/b/sel.
  - owner <= N.
  - state <= EXEC.
- alu_a/b/sel hold their value through EXEC and RESP, and keep it in IDLE until the next accept.
- EXEC: result and flag registers <= alu_out/alu_zero/alu_carry/alu_ovf. State <= RESP.
- RESP:
  - rsp<owner>_valid=1; the other rsp valid is 0.
  - rsp<owner>_result and flags are stable while valid.
  - On rsp<owner>_ready=1: state <= IDLE and prio <= ~owner, so the last-served requester gets lowest priority.
  - Response backpressure may last any number of cycles.
- The non-owner rspN_result/flags show the captured registers, but are qualified by valid only.
- Latency: request accepted at edge T -> rsp_valid high in cycle T+2. Minimum 3 cycles per operation (accept, EXEC, RESP with ready=1).
- A new request cannot be accepted in the same cycle a response completes. The next accept is in the following IDLE cycle.
- Opcodes pass through without checking. Unlisted codes reach the ALU, which applies its default (add).
  - Defined codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1111 EQ.
- A request whose valid drops before acceptance is ignored; no state changes.
- Reset, values after the first rst edge:
  - state=IDLE, prio=PRIO_INIT, owner=0.
  - alu_a/alu_b/alu_sel=0.
  - result and flag registers=0.
  - all rsp valids=0.
  - all req readies=0 while rst=1.
- Reset in EXEC or RESP discards the in-flight operation; no response is issued.
- rst has priority over every other event.

Test Plan:
- Single op on req0: a=0x7FFFFFFF, b=1, sel=0010, rsp0_ready=1 -> rsp0_valid in cycle T+2 with result=0x80000000, ovf=1, carry=0, zero=0; rsp1_valid stays 0.
- Contention with PRIO_INIT=0: both valid every cycle, req0 SUB 5-5, req1 AND 0xF0&0x0F -> first grant req0 (result 0, zero=1), second grant req1 (result 0, zero=1), third grant req0; grants strictly alternate.
- Backpressure: req1 EQ a=b=0x1234, rsp1_ready low for 5 cycles -> rsp1_valid held with result=1 throughout; req0_ready stays 0; req0 is accepted in the cycle after rsp1_ready=1.
- Carry path: req0 ADD 0xFFFFFFFF+1 -> result=0, carry=1, zero=1, ovf=0. SLT 0xFFFFFFFF<1 -> result=1.
- Reset mid-operation: assert rst in EXEC -> no rsp valid afterwards, state IDLE, alu_a/alu_b/alu_sel=0, prio=PRIO_INIT; the next request is served normally.
- Unlisted opcode 0011 with a=2, b=3 -> result 5 (ALU default add), with normal handshake timing.
